// File: rtl/t3_pkg.sv
// Shared types and constants for the serial byte front end and the byte queue behind it.
// The state encoding is shared so the queue side can decode the deserializer state directly.
package t3_pkg;

    typedef enum logic {
        RECEIVING = 1'b0,
        FULL      = 1'b1
    } deser_state_t;

    localparam int BYTE_W = 8;

endpackage : t3_pkg

// File: rtl/rise_detect.sv
// Single-flop 0->1 edge detector for slow level strobes.
// The history flop follows the level on every clock so a held level never re-triggers.
module rise_detect (
    input  logic clock_1MHz,
    input  logic rst,
    input  logic level_in,
    output logic pulse_out
);

    logic level_q;

    always_ff @(posedge clock_1MHz) begin
        if (!rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_in;
        end
    end

    assign pulse_out = level_in & ~level_q;

endmodule : rise_detect

// File: rtl/serial_byte_deserializer.sv
// Collects WIDTH serial bits (LSB first, one per write_in rising edge) into a word
// and holds it with data_ready_out until the downstream stage acknowledges it.
module serial_byte_deserializer
    import t3_pkg::*;
#(
    parameter int WIDTH = BYTE_W
) (
    input  logic                       clock_1MHz,
    input  logic                       rst,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    output logic                       status_out,
    output logic                       data_ready_out,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(WIDTH+1)-1:0] bit_count_out,
    output logic                       overrun_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    deser_state_t     state_q;
    deser_state_t     state_nxt;
    logic             wr_edge;
    logic             active_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] bit_count_q;
    logic             overrun_q;
    logic             word_done;

    rise_detect u_write_edge (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .level_in   (write_in),
        .pulse_out  (wr_edge)
    );

    assign word_done = (state_q == RECEIVING) && wr_edge && (bit_count_q == LAST_BIT);

    always_ff @(posedge clock_1MHz) begin
        if (!rst) begin
            state_q <= RECEIVING;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ack_in only matters once a word is parked; while receiving it is ignored.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RECEIVING: if (word_done) state_nxt = FULL;
            FULL:      if (ack_in)    state_nxt = RECEIVING;
            default:   state_nxt = RECEIVING;
        endcase
    end

    always_ff @(posedge clock_1MHz) begin
        if (!rst) begin
            active_q    <= 1'b0;
            shift_q     <= '0;
            word_q      <= '0;
            bit_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (state_q == RECEIVING) begin
                if (wr_edge) begin
                    shift_q <= {data_in, shift_q[WIDTH-1:1]};
                    if (word_done) begin
                        word_q      <= {data_in, shift_q[WIDTH-1:1]};
                        bit_count_q <= '0;
                    end else begin
                        bit_count_q <= bit_count_q + 1'b1;
                    end
                end
            end else if (wr_edge) begin
                // Bit arrives with nowhere to go: drop it, even if ack_in frees the slot on this edge.
                overrun_q <= 1'b1;
            end
        end
    end

    // active_q keeps status_out low for the reset edge itself.
    assign status_out     = active_q && (state_q == RECEIVING);
    assign data_ready_out = (state_q == FULL);
    assign data_out       = word_q;
    assign bit_count_out  = bit_count_q;
    assign overrun_out    = overrun_q;

endmodule : serial_byte_deserializer

// File: tb/tb_serial_byte_deserializer.sv
// Directed-vector bench for serial_byte_deserializer: reset, word capture, ack handshake,
// overrun, mid-word reset and held-strobe behaviour, all against hand-computed values.
`timescale 1ns/1ps
module tb_serial_byte_deserializer;

    logic       clock_1MHz = 1'b0;
    logic       rst        = 1'b0;
    logic       data_in    = 1'b0;
    logic       write_in   = 1'b0;
    logic       ack_in     = 1'b0;
    logic       status_out;
    logic       data_ready_out;
    logic [7:0] data_out;
    logic [3:0] bit_count_out;
    logic       overrun_out;

    int n_vec = 0;
    int n_err = 0;

    serial_byte_deserializer #(.WIDTH(8)) dut (
        .clock_1MHz     (clock_1MHz),
        .rst            (rst),
        .data_in        (data_in),
        .write_in       (write_in),
        .ack_in         (ack_in),
        .status_out     (status_out),
        .data_ready_out (data_ready_out),
        .data_out       (data_out),
        .bit_count_out  (bit_count_out),
        .overrun_out    (overrun_out)
    );

    always #500 clock_1MHz = ~clock_1MHz;

    task automatic tick();
        @(posedge clock_1MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One bit: write_in 10 clk high then 10 clk low.
    task automatic send_bit(input logic b);
        data_in  = b;
        write_in = 1'b1;
        repeat (10) tick();
        write_in = 1'b0;
        data_in  = ~b;
        repeat (10) tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    initial begin
        logic [7:0] w;

        // Test 1: reset
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_status", status_out, 0);
        chk("rst_ready", data_ready_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_count", bit_count_out, 0);
        chk("rst_overrun", overrun_out, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_status", status_out, 1);

        // Test 2: 8'h99 LSB first
        w = 8'h99;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        chk("t2_count7", bit_count_out, 7);
        chk("t2_not_ready", data_ready_out, 0);
        data_in  = w[7];
        write_in = 1'b1;
        tick();
        chk("t2_ready", data_ready_out, 1);
        chk("t2_status", status_out, 0);
        chk("t2_data", data_out, 8'h99);
        chk("t2_count0", bit_count_out, 0);
        repeat (9) tick();
        write_in = 1'b0;
        repeat (10) tick();

        // Test 4: extra pulses while FULL
        chk("t4_no_overrun_yet", overrun_out, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t4_overrun", overrun_out, 1);
        chk("t4_data_held", data_out, 8'h99);
        chk("t4_count", bit_count_out, 0);
        chk("t4_still_ready", data_ready_out, 1);

        // Test 3: ack high 100 clk, then second word
        ack_in = 1'b1;
        tick();
        chk("t3_status", status_out, 1);
        chk("t3_ready_clr", data_ready_out, 0);
        repeat (99) tick();
        ack_in = 1'b0;
        chk("t3_no_double", data_ready_out, 0);
        chk("t3_count", bit_count_out, 0);
        send_byte(8'hA5);
        chk("t3_data_a5", data_out, 8'hA5);
        chk("t3_ready_a5", data_ready_out, 1);
        chk("t3_status_a5", status_out, 0);
        chk("t3_overrun_sticky", overrun_out, 1);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk("t3_ack_a5", data_ready_out, 0);

        // Test 5: partial word then reset
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t5_count5", bit_count_out, 5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_count_rst", bit_count_out, 0);
        chk("t5_overrun_rst", overrun_out, 0);
        chk("t5_data_rst", data_out, 0);
        chk("t5_status_rst", status_out, 0);
        tick();
        chk("t5_status_back", status_out, 1);
        send_byte(8'h3C);
        chk("t5_data_3c", data_out, 8'h3C);
        chk("t5_ready_3c", data_ready_out, 1);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;

        // Test 6: write_in held high from 8th bit through ack
        w = 8'h81;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        data_in  = w[7];
        write_in = 1'b1;
        tick();
        chk("t6_data_81", data_out, 8'h81);
        chk("t6_ready", data_ready_out, 1);
        repeat (5) tick();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk("t6_status", status_out, 1);
        chk("t6_count_ack", bit_count_out, 0);
        repeat (10) tick();
        chk("t6_count_held", bit_count_out, 0);
        chk("t6_no_overrun", overrun_out, 0);
        write_in = 1'b0;
        repeat (10) tick();
        chk("t6_count_low", bit_count_out, 0);
        send_bit(1'b1);
        chk("t6_count_next", bit_count_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_byte_deserializer
